// File: rtl/deser_align.sv
// 1:WIDTH serial deserializer that slips its word boundary one bit at a time
// until ALIGN_PATTERN is seen on LOCK_COUNT consecutive words, then strobes payload.
module deser_align #(
  parameter int                 WIDTH         = 8,
  parameter logic [WIDTH-1:0]   ALIGN_PATTERN = 8'hF0,
  parameter int                 LOCK_COUNT    = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             din,
  input  logic             en,
  input  logic             realign,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             locked
);

  localparam int CNT_W  = $clog2(WIDTH);
  localparam int MCNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    SEARCH,
    CONFIRM,
    LOCKED
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-2:0]   sr;
  logic [CNT_W-1:0]   cnt;
  logic [MCNT_W-1:0]  mcnt;
  logic [MCNT_W-1:0]  mcnt_nxt;
  logic               slip;
  logic               slip_nxt;
  logic [WIDTH-1:0]   new_word;
  logic               boundary;
  logic               match;
  logic               valid_nxt;
  logic               locked_nxt;

  // Only the low WIDTH-1 bits of history are needed; the incoming bit completes the word.
  assign new_word = {sr, din};
  assign boundary = en && (cnt == CNT_LAST) && !slip;
  assign match    = (new_word == ALIGN_PATTERN);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sr       <= '0;
      cnt      <= '0;
      word_out <= '0;
    end else if (en) begin
      sr <= new_word[WIDTH-2:0];
      if (slip) begin
        cnt <= '0;
      end else if (boundary) begin
        cnt      <= '0;
        word_out <= new_word;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= SEARCH;
      mcnt  <= '0;
      slip  <= 1'b0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
      slip  <= slip_nxt;
    end
  end

  // A slip edge swallows one extra bit, so the next boundary lands WIDTH+1 bits later.
  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    slip_nxt  = slip;
    if (en && slip) begin
      slip_nxt = 1'b0;
    end
    if (boundary) begin
      unique case (state)
        SEARCH: begin
          if (match) begin
            if (LOCK_COUNT == 1) begin
              state_nxt = LOCKED;
            end else begin
              state_nxt = CONFIRM;
              mcnt_nxt  = MCNT_W'(1);
            end
          end else begin
            slip_nxt = 1'b1;
          end
        end
        CONFIRM: begin
          if (match) begin
            if (mcnt == MCNT_LAST) begin
              state_nxt = LOCKED;
              mcnt_nxt  = '0;
            end else begin
              mcnt_nxt = mcnt + 1'b1;
            end
          end else begin
            state_nxt = SEARCH;
            mcnt_nxt  = '0;
            slip_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
    if (realign) begin
      state_nxt = SEARCH;
      mcnt_nxt  = '0;
      slip_nxt  = 1'b0;
    end
  end

  // Only boundaries judged while already locked are payload; the lock-completing word is not.
  always_comb begin
    valid_nxt  = boundary && (state == LOCKED) && !realign;
    locked_nxt = (state_nxt == LOCKED);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      word_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      word_valid <= valid_nxt;
      locked     <= locked_nxt;
    end
  end

endmodule
